// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-stage controller.
//   F3_*         : RV32I funct3 size/sign encodings for loads and stores
//   mem_state_t  : memory-stage FSM states
package cpu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MS_IDLE     = 2'd0,
        MS_REQ      = 2'd1,
        MS_WAIT_RSP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Purely combinational alignment helper for the memory stage.
//   i_op         : a load or store is present
//   i_load       : the access is a load (otherwise a store)
//   i_funct3     : RV32I size/sign field
//   i_addr_lo    : low two bits of the byte address
//   i_store_data : unaligned store data (rs2)
//   i_rdata      : read word returned by the data memory
//   o_be         : byte-lane mask (shared by loads and stores)
//   o_wdata      : store data replicated onto every lane it may occupy
//   o_load_data  : extracted and sign/zero-extended load result
//   o_exc        : illegal funct3 or misaligned access
module mem_align
    import cpu_pkg::*;
(
    input  logic        i_op,
    input  logic        i_load,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_exc
);

    logic        w_legal;
    logic        w_half;
    logic        w_word;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_hword;

    // Shift the addressed byte down to lane 0; halves are picked by addr[1].
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_hword   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        w_legal = 1'b0;
        if (i_load) begin
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                      (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
        end else begin
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
        end
        w_half = (i_funct3 == F3_H) || (i_funct3 == F3_HU);
        w_word = (i_funct3 == F3_W);
        o_exc  = i_op & (~w_legal | (w_half & i_addr_lo[0]) | (w_word & (i_addr_lo != 2'b00)));
    end

    always_comb begin
        o_be        = 4'b0000;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            F3_H, F3_HU: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_store_data[15:0]}};
            end
            F3_W: begin
                o_be    = 4'b1111;
            end
            default: begin
                o_be    = 4'b0000;
            end
        endcase
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h000000, w_byte};
            F3_H:    o_load_data = {{16{w_hword[15]}}, w_hword};
            F3_HU:   o_load_data = {16'h0000, w_hword};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: consumer end of the EX/MEM register.
// Issues data-memory requests, holds the pipeline with mem_stall while an
// access is outstanding, formats load data and flags exceptions/timeouts.
//   clk, rst              : clock, synchronous active-high reset
//   m_MemRead/m_MemWrite  : load/store in the memory stage (both => load)
//   m_funct3, m_alu_out   : access size/sign and byte address
//   m_mem_data            : store data
//   mem_stall             : hold EX/MEM and upstream stages
//   m_load_data/_valid    : load result and its 1-cycle completion pulse
//   m_mem_exc             : 1-cycle pulse, misaligned/illegal access, no bus op
//   m_bus_err             : 1-cycle pulse, bus timeout, op abandoned
//   dmem_*                : data-memory request/response bus
module mem_stage_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_MemRead,
    input  logic        m_MemWrite,
    input  logic [2:0]  m_funct3,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_mem_data,
    output logic        mem_stall,
    output logic [31:0] m_load_data,
    output logic        m_load_valid,
    output logic        m_mem_exc,
    output logic        m_bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    mem_state_t      r_state;
    mem_state_t      w_next;
    logic [TO_W-1:0] r_to_cnt;

    logic        w_op;
    logic        w_is_load;
    logic        w_exc;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_fmt;
    logic        w_timeout;
    logic        w_cnt_clr;
    logic        w_cnt_inc;

    assign w_op      = m_MemRead | m_MemWrite;
    assign w_is_load = m_MemRead;  // a simultaneous write is dropped
    assign w_timeout = (r_to_cnt == TO_LAST);

    mem_align u_align (
        .i_op         (w_op),
        .i_load       (w_is_load),
        .i_funct3     (m_funct3),
        .i_addr_lo    (m_alu_out[1:0]),
        .i_store_data (m_mem_data),
        .i_rdata      (dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_fmt),
        .o_exc        (w_exc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= MS_IDLE;
            r_to_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_cnt_clr) begin
                r_to_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        dmem_req     = 1'b0;
        mem_stall    = 1'b0;
        m_load_valid = 1'b0;
        m_load_data  = 32'h0;
        m_mem_exc    = 1'b0;
        m_bus_err    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            MS_IDLE: begin
                if (w_op) begin
                    if (w_exc) begin
                        m_mem_exc = 1'b1;
                    end else begin
                        dmem_req = 1'b1;
                        if (dmem_ready) begin
                            // Stores finish on acceptance; loads await rvalid.
                            if (w_is_load) begin
                                w_next    = MS_WAIT_RSP;
                                mem_stall = 1'b1;
                                w_cnt_clr = 1'b1;
                            end
                        end else begin
                            w_next    = MS_REQ;
                            mem_stall = 1'b1;
                            w_cnt_clr = 1'b1;
                        end
                    end
                end
            end
            MS_REQ: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    if (w_is_load) begin
                        w_next    = MS_WAIT_RSP;
                        mem_stall = 1'b1;
                        w_cnt_clr = 1'b1;
                    end else begin
                        w_next = MS_IDLE;
                    end
                end else if (w_timeout) begin
                    m_bus_err    = 1'b1;
                    m_load_valid = w_is_load;
                    w_next       = MS_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    w_cnt_inc = 1'b1;
                end
            end
            MS_WAIT_RSP: begin
                if (dmem_rvalid) begin
                    m_load_valid = 1'b1;
                    m_load_data  = w_fmt;
                    w_next       = MS_IDLE;
                end else if (w_timeout) begin
                    m_bus_err    = 1'b1;
                    m_load_valid = 1'b1;
                    w_next       = MS_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_next = MS_IDLE;
            end
        endcase
    end

    // Request fields are only driven while a request is on the bus.
    assign dmem_addr  = dmem_req ? {m_alu_out[31:2], 2'b00} : 32'h0;
    assign dmem_be    = dmem_req ? w_be : 4'b0000;
    assign dmem_wdata = dmem_req ? w_wdata : 32'h0;
    assign dmem_we    = dmem_req & ~w_is_load;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    localparam int T = 6;

    logic        clk;
    logic        rst;
    logic        m_MemRead;
    logic        m_MemWrite;
    logic [2:0]  m_funct3;
    logic [31:0] m_alu_out;
    logic [31:0] m_mem_data;
    logic        mem_stall;
    logic [31:0] m_load_data;
    logic        m_load_valid;
    logic        m_mem_exc;
    logic        m_bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int n_checks;
    int n_fail;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .m_MemRead    (m_MemRead),
        .m_MemWrite   (m_MemWrite),
        .m_funct3     (m_funct3),
        .m_alu_out    (m_alu_out),
        .m_mem_data   (m_mem_data),
        .mem_stall    (mem_stall),
        .m_load_data  (m_load_data),
        .m_load_valid (m_load_valid),
        .m_mem_exc    (m_mem_exc),
        .m_bus_err    (m_bus_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic int access_bytes(input logic [2:0] f3);
        return int'(1) << f3[1:0];
    endfunction

    function automatic bit ref_exc(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] a);
        bit legal;
        if (!ld && !st) return 1'b0;
        if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        if (!legal) return 1'b1;
        return (int'(a % 4) % access_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int mask;
        mask = ((int'(1) << access_bytes(f3)) - 1) << int'(a % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (access_bytes(f3))
            1:       return {24'h0, d[7:0]} * 32'h01010101;
            2:       return {16'h0, d[15:0]} * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        longint v;
        int     nb;
        nb = access_bytes(f3);
        v  = longint'(rd) >> (8 * int'(a % 4));
        if (nb < 4) begin
            v = v & ((longint'(1) << (8 * nb)) - 1);
            if (!f3[2] && (((v >> (8 * nb - 1)) & 1) == 1)) v = v - (longint'(1) << (8 * nb));
        end
        return v[31:0];
    endfunction

    // One memory op. rdly: cycles until dmem_ready (0 = same cycle);
    // vdly: cycles after acceptance until rvalid (>=1). Values beyond T time out.
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input int rdly, input int vdly, input logic [31:0] rdata);
        bit is_ld;
        bit accepted;
        bit got;
        bit last;
        int jend;
        int iend;
        is_ld = ld;
        @(negedge clk);
        m_MemRead   = ld;
        m_MemWrite  = st;
        m_funct3    = f3;
        m_alu_out   = a;
        m_mem_data  = d;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        if (ref_exc(ld, st, f3, a)) begin
            #1;
            check_eq("exc_pulse", 32'(m_mem_exc), 32'd1);
            check_eq("exc_noreq", 32'(dmem_req), 32'd0);
            check_eq("exc_stall", 32'(mem_stall), 32'd0);
            check_eq("exc_lvalid", 32'(m_load_valid), 32'd0);
            return;
        end
        accepted = (rdly <= T);
        jend     = accepted ? rdly : T;
        for (int j = 0; j <= jend; j++) begin
            if (j > 0) @(negedge clk);
            last        = (j == jend);
            dmem_ready  = accepted && last;
            dmem_rvalid = dmem_ready ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            check_eq("req", 32'(dmem_req), 32'd1);
            check_eq("addr", dmem_addr, {a[31:2], 2'b00});
            check_eq("be", 32'(dmem_be), 32'(ref_be(f3, a)));
            check_eq("we", 32'(dmem_we), 32'(!is_ld));
            if (!is_ld) check_eq("wdata", dmem_wdata, ref_wdata(f3, d));
            check_eq("req_stall", 32'(mem_stall), 32'(!last || (accepted && is_ld)));
            check_eq("req_buserr", 32'(m_bus_err), 32'(last && !accepted));
            check_eq("req_lvalid", 32'(m_load_valid), 32'(last && !accepted && is_ld));
            if (last && !accepted && is_ld) check_eq("to_ldata", m_load_data, 32'h0);
        end
        if (!(accepted && is_ld)) return;
        got  = (vdly <= T);
        iend = got ? vdly - 1 : T - 1;
        for (int i = 0; i <= iend; i++) begin
            @(negedge clk);
            last        = (i == iend);
            dmem_ready  = 1'b0;
            dmem_rvalid = got && last;
            dmem_rdata  = dmem_rvalid ? rdata : $urandom;
            #1;
            check_eq("wait_req", 32'(dmem_req), 32'd0);
            check_eq("wait_stall", 32'(mem_stall), 32'(!last));
            check_eq("wait_lvalid", 32'(m_load_valid), 32'(last));
            check_eq("wait_buserr", 32'(m_bus_err), 32'(last && !got));
            if (last) check_eq("ldata", m_load_data, got ? ref_load(f3, a, rdata) : 32'h0);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        m_MemRead   = 1'b0;
        m_MemWrite  = 1'b0;
        m_funct3    = 3'($urandom);
        m_alu_out   = $urandom;
        m_mem_data  = $urandom;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        #1;
        check_eq("idle_stall", 32'(mem_stall), 32'd0);
        check_eq("idle_req", 32'(dmem_req), 32'd0);
        check_eq("idle_lvalid", 32'(m_load_valid), 32'd0);
        check_eq("idle_flags", 32'({m_mem_exc, m_bus_err}), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_stall"}, 32'(mem_stall), 32'd0);
        check_eq({tag, "_req"}, 32'(dmem_req), 32'd0);
        check_eq({tag, "_we"}, 32'(dmem_we), 32'd0);
        check_eq({tag, "_be"}, 32'(dmem_be), 32'd0);
        check_eq({tag, "_addr"}, dmem_addr, 32'd0);
        check_eq({tag, "_wdata"}, dmem_wdata, 32'd0);
        check_eq({tag, "_ldata"}, m_load_data, 32'd0);
        check_eq({tag, "_pulses"}, 32'({m_load_valid, m_mem_exc, m_bus_err}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel;
        bit          ld;
        bit          st;
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        m_MemRead   = 1'b0;
        m_MemWrite  = 1'b0;
        m_funct3    = 3'd0;
        m_alu_out   = 32'h0;
        m_mem_data  = 32'h0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("reset");

        // Directed cases
        run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0);     // SW, ready at once
        run_op(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 3, 1, 32'h0);     // SB, late ready
        run_op(1'b1, 1'b0, 3'b000, 32'h301, 32'h0, 0, 2, 32'h12348000);     // LB
        run_op(1'b1, 1'b0, 3'b100, 32'h301, 32'h0, 1, 2, 32'h12348000);     // LBU
        run_op(1'b1, 1'b0, 3'b101, 32'h302, 32'h0, 0, 2, 32'hBEEF0000);     // LHU
        run_op(1'b1, 1'b0, 3'b010, 32'h106, 32'h0, 0, 1, 32'h0);            // LW misaligned
        run_op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 1, 32'h0);            // illegal funct3
        run_op(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 1, 32'h0);            // illegal store funct3
        run_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 0, T + 4, 32'h0);        // response timeout
        run_op(1'b1, 1'b0, 3'b001, 32'h502, 32'h0, 0, 1, 32'h80017FFF);     // LH right after
        run_op(1'b0, 1'b1, 3'b001, 32'h602, 32'h1234CAFE, T + 3, 1, 32'h0); // request timeout
        run_op(1'b0, 1'b1, 3'b001, 32'h602, 32'h1234CAFE, T, 1, 32'h0);     // ready on last cycle
        run_op(1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 0, T, 32'hA5A55A5A);     // rvalid on last cycle
        run_op(1'b1, 1'b1, 3'b010, 32'h704, 32'hFFFFFFFF, 2, 3, 32'h0BADF00D); // both set: load
        idle_cycle();

        // Reset while waiting for a load response
        @(negedge clk);
        m_MemRead  = 1'b1;
        m_MemWrite = 1'b0;
        m_funct3   = 3'b010;
        m_alu_out  = 32'h400;
        dmem_ready = 1'b1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        check_eq("rst_pre_stall", 32'(mem_stall), 32'd1);
        @(negedge clk);
        rst        = 1'b1;
        m_MemRead  = 1'b0;
        m_funct3   = 3'b000;
        m_alu_out  = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h11223344;
        #1;
        check_eq("late_rvalid_lv", 32'(m_load_valid), 32'd0);
        check_eq("late_rvalid_stall", 32'(mem_stall), 32'd0);
        run_op(1'b1, 1'b0, 3'b000, 32'h803, 32'h0, 1, 1, 32'h7F000000);

        // Randomized ops
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            ld  = (sel <= 5);
            st  = (sel == 0) || (sel >= 6);
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom);
            end
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a = a & ~(32'(access_bytes(f3)) - 32'd1) & 32'hFFFF_FFFC | (a & 32'h3 & ~(32'(access_bytes(f3)) - 32'd1));
            run_op(ld, st, f3, a, $urandom,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 2) : $urandom_range(0, 2),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, T + 2) : $urandom_range(1, 3),
                   $urandom);
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
